// File: rtl/avalon_core_csr.sv
// avalon_core_csr: Avalon-MM control/status slave that holds input words, launches a
// multi-cycle core and captures its results. Define CSR_IRQ_EN to build the interrupt.
module avalon_core_csr #(
    parameter int DW    = 32,
    parameter int N_IN  = 8,
    parameter int N_OUT = 4,
    parameter int AW    = 4
) (
    input  logic                CLK,
    input  logic                RESET_N,
    input  logic                AVL_CS,
    input  logic                AVL_READ,
    input  logic                AVL_WRITE,
    input  logic [AW-1:0]       AVL_ADDR,
    input  logic [DW/8-1:0]     AVL_BYTE_EN,
    input  logic [DW-1:0]       AVL_WRITEDATA,
    output logic [DW-1:0]       AVL_READDATA,
    output logic                AVL_READDATAVALID,
    output logic [N_IN*DW-1:0]  CORE_IN,
    output logic                CORE_START,
    input  logic                CORE_DONE,
    input  logic [N_OUT*DW-1:0] CORE_RES,
    output logic                IRQ
);
    localparam int NB       = DW / 8;
    localparam int CTRL_A   = N_IN + N_OUT;
    localparam int STATUS_A = CTRL_A + 1;
    localparam int CYCLES_A = CTRL_A + 2;

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] in_q  [N_IN];
    logic [DW-1:0] res_q [N_OUT];
    logic [DW-1:0] cycles_q;
    logic [DW-1:0] rd_data;
    logic          done_q;
    logic          irq_en_q;
    logic          wr_en, rd_en;
    logic          start_acc, done_acc, w1c;
    int            addr_i;

    assign addr_i = int'(AVL_ADDR);
    assign wr_en  = AVL_CS & AVL_WRITE;
    // A simultaneous write wins; the read gets no response.
    assign rd_en  = AVL_CS & AVL_READ & ~AVL_WRITE;

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        start_acc = 1'b0;
        done_acc  = 1'b0;
        w1c       = wr_en && (addr_i == STATUS_A) && AVL_BYTE_EN[0] && AVL_WRITEDATA[1];
        case (state_q)
            IDLE: begin
                start_acc = wr_en && (addr_i == CTRL_A) && AVL_BYTE_EN[0] && AVL_WRITEDATA[0];
                if (start_acc) state_d = RUN;
            end
            RUN: begin
                done_acc = CORE_DONE;
                if (done_acc) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= IDLE;
            CORE_START <= 1'b0;
            done_q     <= 1'b0;
            cycles_q   <= '0;
        end else begin
            state_q    <= state_d;
            CORE_START <= start_acc;
            if (start_acc)     done_q <= 1'b0;
            else if (done_acc) done_q <= 1'b1;
            else if (w1c)      done_q <= 1'b0;
            if (start_acc)
                cycles_q <= DW'(1);
            else if (state_q == RUN && cycles_q != '1)
                cycles_q <= cycles_q + DW'(1);
        end
    end

    // NOTE: the register files are reset because software must read zeros after reset.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < N_IN; i++) in_q[i] <= '0;
        end else if (wr_en && state_q == IDLE) begin
            for (int i = 0; i < N_IN; i++)
                for (int b = 0; b < NB; b++)
                    if (addr_i == i && AVL_BYTE_EN[b])
                        in_q[i][b*8 +: 8] <= AVL_WRITEDATA[b*8 +: 8];
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < N_OUT; i++) res_q[i] <= '0;
        end else if (done_acc) begin
            for (int i = 0; i < N_OUT; i++) res_q[i] <= CORE_RES[i*DW +: DW];
        end
    end

    for (genvar g = 0; g < N_IN; g++) begin : g_core_in
        assign CORE_IN[g*DW +: DW] = in_q[g];
    end

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < N_IN; i++)
            if (addr_i == i) rd_data = in_q[i];
        for (int i = 0; i < N_OUT; i++)
            if (addr_i == N_IN + i) rd_data = res_q[i];
        if (addr_i == CTRL_A) rd_data[1] = irq_en_q;
        if (addr_i == STATUS_A) begin
            rd_data[0] = (state_q == RUN);
            rd_data[1] = done_q;
        end
        if (addr_i == CYCLES_A) rd_data = cycles_q;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            AVL_READDATA      <= '0;
            AVL_READDATAVALID <= 1'b0;
        end else begin
            AVL_READDATAVALID <= rd_en;
            if (rd_en) AVL_READDATA <= rd_data;
        end
    end

`ifdef CSR_IRQ_EN
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            irq_en_q <= 1'b0;
            IRQ      <= 1'b0;
        end else begin
            if (wr_en && addr_i == CTRL_A && AVL_BYTE_EN[0]) irq_en_q <= AVL_WRITEDATA[1];
            IRQ <= done_q & irq_en_q;
        end
    end
`else
    assign irq_en_q = 1'b0;
    assign IRQ      = 1'b0;
`endif

endmodule

// File: tb/tb_avalon_core_csr.sv
// Self-checking bench for avalon_core_csr: directed steps plus randomized traffic checked
// against a register-level behavioural model. IRQ expectations follow CSR_IRQ_EN.
module tb_avalon_core_csr;
    localparam int DW = 32, N_IN = 8, N_OUT = 4, AW = 4;
    localparam int CTRL_A = N_IN + N_OUT, STATUS_A = CTRL_A + 1, CYCLES_A = CTRL_A + 2;

    logic                CLK = 1'b0;
    logic                RESET_N = 1'b0;
    logic                AVL_CS = 1'b0, AVL_READ = 1'b0, AVL_WRITE = 1'b0;
    logic [AW-1:0]       AVL_ADDR = '0;
    logic [DW/8-1:0]     AVL_BYTE_EN = '0;
    logic [DW-1:0]       AVL_WRITEDATA = '0;
    logic [DW-1:0]       AVL_READDATA;
    logic                AVL_READDATAVALID;
    logic [N_IN*DW-1:0]  CORE_IN;
    logic                CORE_START;
    logic                CORE_DONE = 1'b0;
    logic [N_OUT*DW-1:0] CORE_RES = '0;
    logic                IRQ;

    avalon_core_csr #(.DW(DW), .N_IN(N_IN), .N_OUT(N_OUT), .AW(AW)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .AVL_CS(AVL_CS), .AVL_READ(AVL_READ),
        .AVL_WRITE(AVL_WRITE), .AVL_ADDR(AVL_ADDR), .AVL_BYTE_EN(AVL_BYTE_EN),
        .AVL_WRITEDATA(AVL_WRITEDATA), .AVL_READDATA(AVL_READDATA),
        .AVL_READDATAVALID(AVL_READDATAVALID), .CORE_IN(CORE_IN), .CORE_START(CORE_START),
        .CORE_DONE(CORE_DONE), .CORE_RES(CORE_RES), .IRQ(IRQ)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0, n_err = 0;
    int edge_cnt = 0;
    int n_start = 0, n_start_m = 0;

    always @(posedge CLK) edge_cnt <= edge_cnt + 1;
    always @(negedge CLK) if (CORE_START) n_start <= n_start + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: observed no end, required finish before time limit");
        $fatal(1);
    end

    // Behavioural register model
    logic [31:0] in_m [N_IN];
    logic [31:0] res_m [N_OUT];
    logic [31:0] cyc_m, last_rd;
    bit          busy_m, done_m, irqen_m;
    int          start_e;

    task automatic m_reset();
        for (int i = 0; i < N_IN; i++) in_m[i] = '0;
        for (int i = 0; i < N_OUT; i++) res_m[i] = '0;
        cyc_m = '0; busy_m = 0; done_m = 0; irqen_m = 0; start_e = 0; last_rd = '0;
    endtask

    task automatic m_write(input int a, input logic [3:0] be, input logic [31:0] d, input int e);
        if (a < N_IN) begin
            if (!busy_m)
                for (int b = 0; b < 4; b++) if (be[b]) in_m[a][b*8 +: 8] = d[b*8 +: 8];
        end else if (a == CTRL_A && be[0]) begin
`ifdef CSR_IRQ_EN
            irqen_m = d[1];
`endif
            if (d[0] && !busy_m) begin
                busy_m = 1; done_m = 0; start_e = e; n_start_m++;
            end
        end else if (a == STATUS_A && be[0] && d[1]) begin
            done_m = 0;
        end
    endtask

    task automatic m_done(input int e, input logic [127:0] r);
        if (busy_m) begin
            for (int i = 0; i < N_OUT; i++) res_m[i] = r[i*32 +: 32];
            done_m = 1; busy_m = 0;
            cyc_m = 32'(e - start_e + 1);
        end
    endtask

    // Value a read sampled at edge e returns (state before that edge).
    function automatic logic [31:0] m_read(input int a, input int e);
        logic [31:0] v;
        v = '0;
        if (a < N_IN)                v = in_m[a];
        else if (a < N_IN + N_OUT)   v = res_m[a - N_IN];
        else if (a == CTRL_A)        v[1] = irqen_m;
        else if (a == STATUS_A)      v = {30'd0, done_m, busy_m};
        else if (a == CYCLES_A)      v = busy_m ? 32'(e - start_e) : cyc_m;
        return v;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One clock of bus/core activity, driven and checked just after the falling edge.
    task automatic bus(input string tag, input bit cs, input bit wr, input bit rd, input int a,
                       input logic [3:0] be, input logic [31:0] d, input bit done,
                       input logic [127:0] r);
        logic [31:0] exp_rd;
        bit          exp_irq, resp;
        AVL_CS = cs; AVL_WRITE = wr; AVL_READ = rd; AVL_ADDR = a[AW-1:0];
        AVL_BYTE_EN = be; AVL_WRITEDATA = d; CORE_DONE = done; CORE_RES = r;
        exp_rd = m_read(a, edge_cnt + 1);
        resp = cs && rd && !wr;
`ifdef CSR_IRQ_EN
        exp_irq = done_m & irqen_m;
`else
        exp_irq = 0;
`endif
        @(negedge CLK); #1;
        AVL_CS = 0; AVL_WRITE = 0; AVL_READ = 0; CORE_DONE = 0;
        if (cs && wr) m_write(a, be, d, edge_cnt);
        if (done) m_done(edge_cnt, r);
        check({tag, " valid"}, 32'(AVL_READDATAVALID), 32'(resp));
        if (resp) begin
            check({tag, " data"}, AVL_READDATA, exp_rd);
            last_rd = exp_rd;
        end else begin
            check({tag, " hold"}, AVL_READDATA, last_rd);
        end
        check({tag, " irq"}, 32'(IRQ), 32'(exp_irq));
    endtask

    task automatic rd(input string tag, input int a);
        bus(tag, 1, 1, 0 == 1, a, 4'h0, 32'h0, 0, '0);
    endtask

    task automatic read(input string tag, input int a);
        bus(tag, 1, 0, 1, a, 4'h0, 32'h0, 0, '0);
    endtask

    task automatic write(input string tag, input int a, input logic [3:0] be, input logic [31:0] d);
        bus(tag, 1, 1, 0, a, be, d, 0, '0);
    endtask

    task automatic idle(input string tag);
        bus(tag, 0, 0, 0, 0, 4'h0, 32'h0, 0, '0);
    endtask

    task automatic check_core_in(input string tag);
        for (int i = 0; i < N_IN; i++) check(tag, CORE_IN[i*DW +: DW], in_m[i]);
    endtask

    task automatic pulse_reset(input string tag);
        #2 RESET_N = 0;
        #1;
        check({tag, " readdata"}, AVL_READDATA, 32'h0);
        check({tag, " valid"}, 32'(AVL_READDATAVALID), 32'h0);
        check({tag, " core_start"}, 32'(CORE_START), 32'h0);
        check({tag, " irq"}, 32'(IRQ), 32'h0);
        m_reset();
        check_core_in({tag, " core_in"});
        @(negedge CLK); #1 RESET_N = 1;
    endtask

    logic [127:0] res;
    logic [31:0]  saved;
    int           dly;
    bit           w;

    initial begin
        m_reset();
        @(negedge CLK); @(negedge CLK); #1;
        check("por readdata", AVL_READDATA, 32'h0);
        check("por valid", 32'(AVL_READDATAVALID), 32'h0);
        check("por core_start", 32'(CORE_START), 32'h0);
        check("por irq", 32'(IRQ), 32'h0);
        RESET_N = 1;
        for (int a = 0; a < 16; a++) begin
            read("por map", a);
            check("por map zero", AVL_READDATA, 32'h0);
        end

        // Byte lanes, including an all-disabled pattern and chip select low
        write("in0 full", 0, 4'hF, 32'hAABBCCDD);
        write("in0 lanes", 0, 4'h5, 32'h11223344);
        read("in0 rd", 0);
        check("in0 lanes value", AVL_READDATA, 32'hAA22CC44);
        write("in0 be0", 0, 4'h0, 32'h55667788);
        bus("in0 cs0", 0, 1, 0, 0, 4'hF, 32'h99999999, 0, '0);
        read("in0 rd2", 0);
        check("in0 untouched", AVL_READDATA, 32'hAA22CC44);

        // Random register traffic, back-to-back reads over the whole map
        for (int k = 0; k < 24; k++)
            write("rnd in", $urandom_range(0, N_IN - 1), 4'($urandom), $urandom);
        check_core_in("core_in rnd");
        for (int k = 0; k < 24; k++) read("rnd rd", $urandom_range(0, 15));
        idle("idle hold");

        // Read and write together: write lands, no read response
        bus("rw both", 1, 1, 1, 1, 4'hF, 32'hCAFEF00D, 0, '0);
        read("rw check", 1);
        check("rw value", AVL_READDATA, 32'hCAFEF00D);

        // Disabled lane on CTRL must not launch
        write("ctrl be0", CTRL_A, 4'h0, 32'h1);
        write("ro writes", N_IN, 4'hF, 32'hFFFFFFFF);
        write("cyc write", CYCLES_A, 4'hF, 32'hFFFFFFFF);
        read("status idle", STATUS_A);
        check("status idle value", AVL_READDATA, 32'h0);

        // Full operation with lockout
        saved = in_m[0];
        write("start", CTRL_A, 4'h1, 32'h1);
        check("start pulse", 32'(CORE_START), 32'h1);
        read("status run", STATUS_A);
        check("status run value", AVL_READDATA, 32'h1);
        check("start pulse end", 32'(CORE_START), 32'h0);
        write("lock in0", 0, 4'hF, 32'h12345678);
        write("lock start", CTRL_A, 4'h1, 32'h1);
        read("cycles run", CYCLES_A);
        while (edge_cnt < start_e + 9) idle("op wait");
        res = {$urandom, $urandom, $urandom, 32'hDEADBEEF};
        bus("op done", 0, 0, 0, 0, 4'h0, 32'h0, 1, res);
        read("op status", STATUS_A);
        check("op status value", AVL_READDATA, 32'h2);
        read("op cycles", CYCLES_A);
        check("op cycles value", AVL_READDATA, 32'd11);
        read("op res0", N_IN);
        check("op res0 value", AVL_READDATA, 32'hDEADBEEF);
        read("op in0", 0);
        check("op in0 locked", AVL_READDATA, saved);
        check("op one start", 32'(n_start), 32'h1);

        // Late CORE_DONE in IDLE is ignored
        bus("idle done", 0, 0, 0, 0, 4'h0, 32'h0, 1, {4{32'h0BADF00D}});
        read("idle done res0", N_IN);
        check("idle done res0 value", AVL_READDATA, 32'hDEADBEEF);

        // Earliest CORE_DONE and set-beats-clear race
        write("race start", CTRL_A, 4'h1, 32'h1);
        bus("race done", 1, 1, 0, STATUS_A, 4'h1, 32'h2, 1, {$urandom, $urandom, $urandom, $urandom});
        read("race status", STATUS_A);
        check("race done set", AVL_READDATA, 32'h2);
        read("race cycles", CYCLES_A);
        check("race cycles value", AVL_READDATA, 32'd2);
        write("race clear", STATUS_A, 4'h1, 32'h2);
        read("race status2", STATUS_A);
        check("race done clear", AVL_READDATA, 32'h0);

        // Interrupt behaviour
        write("irq en", CTRL_A, 4'h1, 32'h2);
        write("irq start", CTRL_A, 4'h1, 32'h3);
        idle("irq wait");
        bus("irq done", 0, 0, 0, 0, 4'h0, 32'h0, 1, '0);
        idle("irq settle");
`ifdef CSR_IRQ_EN
        check("irq set", 32'(IRQ), 32'h1);
`else
        check("irq off", 32'(IRQ), 32'h0);
`endif
        write("irq clear", STATUS_A, 4'h1, 32'h2);
        idle("irq drop");
        check("irq cleared", 32'(IRQ), 32'h0);
        write("irq dis", CTRL_A, 4'h1, 32'h0);

        // Randomized operations with traffic during RUN; STATUS read on the DONE edge
        for (int k = 0; k < 8; k++) begin
            for (int j = 0; j < 3; j++)
                write("rop in", $urandom_range(0, N_IN - 1), 4'($urandom), $urandom);
            write("rop start", CTRL_A, 4'h1, {30'd0, 1'($urandom), 1'b1});
            dly = $urandom_range(1, 15);
            while (edge_cnt < start_e + dly - 1) begin
                w = 1'($urandom);
                bus("rop run", 1, w, !w, $urandom_range(0, 15), 4'($urandom), $urandom, 0, '0);
            end
            res = {$urandom, $urandom, $urandom, $urandom};
            bus("rop done", 1, 0, 1, STATUS_A, 4'h0, 32'h0, 1, res);
            for (int a = N_IN; a <= CYCLES_A; a++) read("rop rd", a);
            check_core_in("rop core_in");
            idle("rop gap");
        end
        check("start count", 32'(n_start), 32'(n_start_m));

        // Asynchronous reset mid-cycle, then mid-RUN abort with late CORE_DONE
        read("pre rst", N_IN);
        pulse_reset("rst1");
        for (int a = 0; a < 16; a++) begin
            read("rst map", a);
            check("rst map zero", AVL_READDATA, 32'h0);
        end
        write("abort in", 2, 4'hF, 32'h13579BDF);
        write("abort start", CTRL_A, 4'h1, 32'h1);
        idle("abort run");
        idle("abort run");
        pulse_reset("rst2");
        bus("late done", 0, 0, 0, 0, 4'h0, 32'h0, 1, {4{32'h7777AAAA}});
        read("abort status", STATUS_A);
        check("abort status value", AVL_READDATA, 32'h0);
        read("abort res0", N_IN);
        check("abort res0 value", AVL_READDATA, 32'h0);
        read("abort in2", 2);
        check("abort in2 value", AVL_READDATA, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
